// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int MEM_DEPTH = 600;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;

    // Sum limit compared one bit wider than the address so base+count cannot wrap.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    localparam logic [5:0] HLT_OPCODE = 6'b010010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        FIN   = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader_checksum_acc.sv
// Running modulo-2^DATA_W sum of accepted data words; used only when
// LOADER_CHECKSUM_EN is defined.
module checksum_acc
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    always_comb begin
        if (clear_i) begin
            sum_d = {DATA_W{1'b0}};
        end else if (enable_i) begin
            sum_d = sum_q + word_i;
        end else begin
            sum_d = sum_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= {DATA_W{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Streams 32-bit words into consecutive memory locations and holds the CPU
// meanwhile. Define LOADER_CHECKSUM_EN to expect a trailing checksum beat.
module program_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              in_ready_q, in_ready_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_dado_q, mem_dado_d;
    logic [ADDR_W-1:0] mem_endereco_q, mem_endereco_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic [ADDR_W:0]   end_s;
    logic              hs_s;
    logic              last_s;
    logic              data_beat_s;
    logic              cs_bad_s;

    assign end_s = {1'b0, base_addr} + {1'b0, word_count};
    assign hs_s  = in_valid & in_ready_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_s;
    logic              clr_s;

    // The extra beat at idx==count carries the checksum and is never written.
    assign last_s      = (idx_q == count_q);
    assign data_beat_s = hs_s & ~last_s;
    assign clr_s       = (state_q == IDLE) & start;
    assign cs_bad_s    = (sum_s != in_data);

    checksum_acc u_checksum_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clr_s),
        .enable_i (data_beat_s),
        .word_i   (in_data),
        .sum_o    (sum_s)
    );
`else
    assign last_s      = (idx_q == (count_q - ADDR_W'(1)));
    assign data_beat_s = hs_s;
    assign cs_bad_s    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= {ADDR_W{1'b0}};
            count_q <= {ADDR_W{1'b0}};
            idx_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = {ADDR_W{1'b0}};
                    if (end_s > MEM_LIMIT) begin
                        state_d = ERR;
                    end else if ((word_count == {ADDR_W{1'b0}}) && !CKSUM_EN) begin
                        state_d = FIN;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (hs_s) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (last_s) begin
                        state_d = cs_bad_s ? ERR : FLUSH;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            FLUSH:   state_d = FIN;
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are Moore-style on the current state, so they appear one cycle
    // after the state transition that causes them.
    always_comb begin
        in_ready_d     = (state_q == LOAD) && !(hs_s && last_s);
        mem_write_d    = data_beat_s;
        mem_dado_d     = mem_dado_q;
        mem_endereco_d = mem_endereco_q;
        if (data_beat_s) begin
            mem_dado_d     = in_data;
            mem_endereco_d = base_q + idx_q;
        end else begin
            mem_dado_d     = mem_dado_q;
            mem_endereco_d = mem_endereco_q;
        end
        busy_d     = (state_q == LOAD) || (state_q == FLUSH) || (state_q == FIN);
        cpu_hold_d = busy_d;
        done_d     = (state_q == FIN);
        error_d    = (state_q == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_dado_q     <= {DATA_W{1'b0}};
            mem_endereco_q <= {ADDR_W{1'b0}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_hold_q     <= 1'b0;
        end else begin
            in_ready_q     <= in_ready_d;
            mem_write_q    <= mem_write_d;
            mem_dado_q     <= mem_dado_d;
            mem_endereco_q <= mem_endereco_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            cpu_hold_q     <= cpu_hold_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_write    = mem_write_q;
    assign mem_dado     = mem_dado_q;
    assign mem_endereco = mem_endereco_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the instruction/data memory write port. It accepts a valid/ready stream of 32-bit instruction words from the disk/serial front end and writes them into consecutive memory locations starting at a given base address. While loading, it holds the CPU. It replaces the hard-coded initial image as the normal way to place programs in memory.

## Interface
- MEM_DEPTH, 600: number of memory words; legal addresses are 0..MEM_DEPTH-1
- ADDR_W, 10: address width
- DATA_W, 32: word width
- clk  input  1  system clock; also drives the memory write clock
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  one-cycle load request; sampled only in IDLE
- base_addr  input  ADDR_W  first memory address; sampled with start
- word_count  input  ADDR_W  number of words to write; sampled with start
- in_data  input  DATA_W  stream word
- in_valid  input  1  stream word valid
- in_ready  output  1  loader can accept a word
- mem_dado  output  DATA_W  write data to memory
- mem_endereco  output  ADDR_W  write address to memory
- mem_write  output  1  write enable to memory
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when a load completes successfully
- error  output  1  one-cycle pulse when a load is rejected or fails
- cpu_hold  output  1  stalls the CPU fetch while high

## Operation
- FSM states: IDLE, LOAD, FLUSH, FIN, ERR.
- IDLE, start=1, word_count=0: go to FIN. No writes occur.
- IDLE, start=1, base_addr+word_count > MEM_DEPTH: go to ERR. No writes occur. The sum is computed at ADDR_W+1 bits, so it cannot wrap.
- IDLE, start=1, otherwise: latch base and count, clear the index, go to LOAD.
- LOAD: in_ready=1.
  - Each handshake (in_valid & in_ready) registers mem_dado=in_data and mem_endereco=base+idx, asserts mem_write for the next cycle, then increments idx.
  - When the accepted beat is the last one, in_ready drops in the following cycle and the FSM goes to FLUSH.
- FLUSH: a one-cycle wait for the final write to commit, then go to FIN.
- FIN: done=1 for one cycle, then return to IDLE.
- ERR: error=1 for one cycle, then return to IDLE.
- busy=1 in LOAD, FLUSH and FIN.
- cpu_hold=1 from the cycle after start is accepted through the FIN cycle inclusive.
- start while not in IDLE is ignored.
- Stream beats while in_ready=0 are not consumed. The source must hold in_data until the handshake.
- The stream may stall (in_valid low) for any number of cycles. The loader simply waits; there is no timeout.
- Reset mid-load: all outputs go to 0 immediately and the FSM returns to IDLE. Memory keeps any words already written.

## Timing
- Reset values: in_ready, mem_write, busy, done, error, cpu_hold all 0; mem_dado and mem_endereco 0.
- All outputs are registered on the rising edge of clk.
- mem_write is high for exactly one cycle per accepted word. mem_dado and mem_endereco are stable for that whole cycle. The memory commits on the next rising edge.
- Throughput is one word per cycle with in_valid held high.
- For N>0 words with no stalls, measured from the start edge:
  - in_ready rises at cycle 1.
  - mem_write pulses in cycles 2..N+1.
  - FLUSH is at cycle N+2 and done at cycle N+3.
- word_count=0: done at cycle 1.
- Range error: error at cycle 1.
- Addresses never wrap. The last written address is base+count-1 ≤ MEM_DEPTH-1.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - LOAD accepts word_count+1 beats.
  - The final beat is a checksum and is not written to memory.
  - Checksum rule: the modulo-2^32 sum of the data words must equal the checksum word. Mismatch ends in ERR (error pulse) instead of FIN.
  - cpu_hold still releases; the data words remain written.
  - word_count=0 still expects one checksum beat equal to 0.
- LOADER_CHECKSUM_EN undefined: exactly word_count beats, no accumulator, and error is raised only on a range rejection.

## Structure
- Shared package loader_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, FIN, ERR);
  - the MEM_DEPTH/ADDR_W/DATA_W defaults;
  - the HLT opcode constant 6'b010010, used by benches to terminate loaded programs.
- Under LOADER_CHECKSUM_EN, one sub-module checksum_acc (clear, enable, word, sum) is natural. Otherwise the block is a single module.

## Test plan
- base=0, count=3, words 0x04000154, 0x54000002, 0x48000000, in_valid held -> mem_write pulses at cycles 2-4 with addresses 0,1,2; done at cycle 6; memory read-back matches.
- base=590, count=11 -> error pulse at cycle 1; in_ready never rises; no mem_write; cpu_hold stays 0.
- base=100, count=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes to addresses 100-103 in order; done 2 cycles after the 4th handshake.
- start re-asserted during LOAD, then rst_n pulled low after 2 of 5 words -> second start ignored; outputs 0 immediately; words at base, base+1 retained; next start works normally.
- count=0 -> done at cycle 1, no writes. With LOADER_CHECKSUM_EN: count=2, words 5, 7, checksum 12 -> done; checksum 13 -> error, both words written.
